// File: rtl/im_pipe_rom_if.sv
// Fetch/load bus of the pipelined instruction memory: fetch request/response plus word load port.
interface im_pipe_rom_if #(
    parameter int ADDR_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_flush;
    logic              f_valid;
    logic [31:0]       f_data;
    logic              f_err;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;

    modport master (
        output f_req, f_addr, f_flush, ld_we, ld_addr, ld_data,
        input  f_valid, f_data, f_err
    );

    modport slave (
        input  f_req, f_addr, f_flush, ld_we, ld_addr, ld_data,
        output f_valid, f_data, f_err
    );
endinterface

// File: rtl/im_pipe_rom.sv
// Pipelined instruction memory for the fetch stage: byte-addressed fetch with 1 or 2 cycle latency,
// flush, and a run-time word load port. Optional per-word even parity under `IM_PARITY_EN.
module im_pipe_rom #(
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 8192,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h3000,
    parameter int                READ_LAT  = 1
) (
    input logic          clk,
    input logic          rst_n,
    im_pipe_rom_if.slave bus
);
    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W-1)'(DEPTH);

    // Word storage; deliberately outside the reset domain so programs survive reset.
    logic [31:0] im [0:DEPTH-1];
`ifdef IM_PARITY_EN
    logic        im_par [0:DEPTH-1];
`endif

    logic [ADDR_W-3:0] w_f_word;
    logic [ADDR_W-3:0] w_ld_word;
    logic              w_f_bad;
    logic              w_ld_bad;
    logic [IDX_W-1:0]  w_f_idx;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [31:0]       w_f_rdata;
    logic              w_f_perr;
    logic              w_f_take;

    assign w_f_word  = bus.f_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign w_ld_word = bus.ld_addr[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
    assign w_f_bad   = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr < BASE_ADDR)
                       || ({1'b0, w_f_word} >= DEPTH_LIM);
    assign w_ld_bad  = (bus.ld_addr[1:0] != 2'b00) || (bus.ld_addr < BASE_ADDR)
                       || ({1'b0, w_ld_word} >= DEPTH_LIM);
    assign w_f_idx   = w_f_word[IDX_W-1:0];
    assign w_ld_idx  = w_ld_word[IDX_W-1:0];
    assign w_f_rdata = im[w_f_idx];
    assign w_f_take  = bus.f_req && !bus.f_flush;

`ifdef IM_PARITY_EN
    assign w_f_perr = (^w_f_rdata) != im_par[w_f_idx];
`else
    assign w_f_perr = 1'b0;
`endif

    always @(posedge clk) begin
        if (bus.ld_we && !w_ld_bad) begin
            im[w_ld_idx] <= bus.ld_data;
`ifdef IM_PARITY_EN
            im_par[w_ld_idx] <= ^bus.ld_data;
`endif
        end
    end

    logic        r_v1;
    logic [31:0] r_d1;
    logic        r_e1;

    // Read-before-write on a same-word collision falls out of the non-blocking memory update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_d1 <= 32'h0;
            r_e1 <= 1'b0;
        end else begin
            r_v1 <= w_f_take;
            if (w_f_take) begin
                r_d1 <= w_f_bad ? 32'h0 : w_f_rdata;
                r_e1 <= w_f_bad || w_f_perr;
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic        r_v2;
        logic [31:0] r_d2;
        logic        r_e2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2 <= 1'b0;
                r_d2 <= 32'h0;
                r_e2 <= 1'b0;
            end else begin
                r_v2 <= r_v1 && !bus.f_flush;
                if (r_v1 && !bus.f_flush) begin
                    r_d2 <= r_d1;
                    r_e2 <= r_e1;
                end
            end
        end

        assign bus.f_valid = r_v2;
        assign bus.f_data  = r_d2;
        assign bus.f_err   = r_e2;
    end else begin : g_lat1
        assign bus.f_valid = r_v1;
        assign bus.f_data  = r_d1;
        assign bus.f_err   = r_e1;
    end
endmodule
